// File: rtl/nes_joypad_pkg.sv
// Shared bit indices and the Wii-to-NES mapping helper for the NES joypad port.
package nes_joypad_pkg;

  localparam int NES_PAD_W = 8;

  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  localparam int WII_UP    = 3;
  localparam int WII_DOWN  = 2;
  localparam int WII_LEFT  = 1;
  localparam int WII_RIGHT = 0;

  localparam int WII_A = 3;
  localparam int WII_B = 2;
  localparam int WII_X = 1;
  localparam int WII_Y = 0;

  localparam int WII_START  = 2;
  localparam int WII_SELECT = 1;
  localparam int WII_HOME   = 0;

  // Opposing d-pad directions cancel so the game never sees an impossible pad.
  function automatic logic [NES_PAD_W-1:0] nes_map(input logic [3:0] udlr,
                                                   input logic a, input logic b,
                                                   input logic sel, input logic start);
    logic [NES_PAD_W-1:0] pad;
    logic ud_clash, lr_clash;
    ud_clash = udlr[WII_UP] & udlr[WII_DOWN];
    lr_clash = udlr[WII_LEFT] & udlr[WII_RIGHT];
    pad = '0;
    pad[NES_A]      = a;
    pad[NES_B]      = b;
    pad[NES_SELECT] = sel;
    pad[NES_START]  = start;
    pad[NES_UP]     = udlr[WII_UP] & ~ud_clash;
    pad[NES_DOWN]   = udlr[WII_DOWN] & ~ud_clash;
    pad[NES_LEFT]   = udlr[WII_LEFT] & ~lr_clash;
    pad[NES_RIGHT]  = udlr[WII_RIGHT] & ~lr_clash;
    return pad;
  endfunction

endpackage

// File: rtl/nes_joypad_turbo.sv
// Turbo phase generator: turbo_phase toggles every TURBO_HALF clocks.
// Only compiled when NES_JOYPAD_TURBO_EN is defined.
`ifdef NES_JOYPAD_TURBO_EN
module nes_joypad_turbo #(
  parameter int unsigned TURBO_HALF = 416_667
) (
  input  logic clk,
  input  logic reset,
  output logic turbo_phase
);

  localparam int unsigned CW = (TURBO_HALF > 1) ? $clog2(TURBO_HALF) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TURBO_HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= RELOAD;
      turbo_phase <= 1'b0;
    end else if (cnt == '0) begin
      cnt         <= RELOAD;
      turbo_phase <= ~turbo_phase;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule
`endif

// File: rtl/nes_joypad_port.sv
// NES controller ($4016) emulation fed by decoded Wii Classic buttons.
// Optional turbo on X/Y enabled by defining NES_JOYPAD_TURBO_EN.
module nes_joypad_port
  import nes_joypad_pkg::*;
#(
  parameter int unsigned TURBO_HALF   = 416_667,
  parameter bit          OPEN_BUS_ONE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           udlr_dpad,
  input  logic [3:0]           abxy_btns,
  input  logic [2:0]           st_sel_hm_btns,
  input  logic                 cpu_wr_stb,
  input  logic                 cpu_wr_d0,
  input  logic                 cpu_rd_stb,
  output logic                 joy_d0,
  output logic [NES_PAD_W-1:0] pad_state
);

  logic [NES_PAD_W-1:0] snap, snap_d, shift_q;
  logic                 strobe_q;
  logic [3:0]           rd_cnt;
  logic                 a_eff, b_eff;
  logic                 unused_ok;

`ifdef NES_JOYPAD_TURBO_EN
  logic turbo_phase;

  nes_joypad_turbo #(.TURBO_HALF(TURBO_HALF)) u_turbo (
    .clk         (clk),
    .reset       (reset),
    .turbo_phase (turbo_phase)
  );

  assign a_eff     = abxy_btns[WII_A] | (abxy_btns[WII_X] & turbo_phase);
  assign b_eff     = abxy_btns[WII_B] | (abxy_btns[WII_Y] & turbo_phase);
  assign unused_ok = &{1'b0, st_sel_hm_btns[WII_HOME]};
`else
  assign a_eff     = abxy_btns[WII_A];
  assign b_eff     = abxy_btns[WII_B];
  assign unused_ok = &{1'b0, abxy_btns[WII_X], abxy_btns[WII_Y],
                       st_sel_hm_btns[WII_HOME], (TURBO_HALF != 0)};
`endif

  assign snap_d = nes_map(udlr_dpad, a_eff, b_eff,
                          st_sel_hm_btns[WII_SELECT], st_sel_hm_btns[WII_START]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) snap <= '0;
    else        snap <= snap_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          strobe_q <= 1'b0;
    else if (cpu_wr_stb) strobe_q <= cpu_wr_d0;
  end

  // A write in the same cycle as a read suppresses the shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      rd_cnt  <= '0;
    end else if (strobe_q) begin
      shift_q <= snap;
      rd_cnt  <= '0;
    end else if (cpu_rd_stb && !cpu_wr_stb) begin
      shift_q <= {OPEN_BUS_ONE, shift_q[NES_PAD_W-1:1]};
      if (rd_cnt != 4'd8) rd_cnt <= rd_cnt + 4'd1;
    end
  end

  assign joy_d0    = strobe_q ? snap[NES_A] : shift_q[0];
  assign pad_state = snap;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Self-checking bench for nes_joypad_port: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_nes_joypad_port;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] udlr_dpad = '0;
  logic [3:0] abxy_btns = '0;
  logic [2:0] st_sel_hm_btns = '0;
  logic       cpu_wr_stb = 1'b0;
  logic       cpu_wr_d0 = 1'b0;
  logic       cpu_rd_stb = 1'b0;
  logic       joy_d0;
  logic [7:0] pad_state;

  always #5 clk = ~clk;

  nes_joypad_port #(.TURBO_HALF(4), .OPEN_BUS_ONE(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .udlr_dpad      (udlr_dpad),
    .abxy_btns      (abxy_btns),
    .st_sel_hm_btns (st_sel_hm_btns),
    .cpu_wr_stb     (cpu_wr_stb),
    .cpu_wr_d0      (cpu_wr_d0),
    .cpu_rd_stb     (cpu_rd_stb),
    .joy_d0         (joy_d0),
    .pad_state      (pad_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: expected byte, strobe level, and the bits the CPU will read next.
  logic [7:0] m_snap;
  logic       m_strobe;
  logic       m_q[$];
  bit         chk_model = 1'b1;

  typedef struct {
    logic [3:0] d;
    logic [3:0] f;
    logic [2:0] s;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [7:0] exp_byte(input logic [3:0] d, input logic [3:0] f,
                                          input logic [2:0] s);
    int up, dn, lf, rt, v;
    up = int'(d[3]); dn = int'(d[2]); lf = int'(d[1]); rt = int'(d[0]);
    if (up == 1 && dn == 1) begin up = 0; dn = 0; end
    if (lf == 1 && rt == 1) begin lf = 0; rt = 0; end
    v = int'(f[3]) + 2 * int'(f[2]) + 4 * int'(s[1]) + 8 * int'(s[2])
      + 16 * up + 32 * dn + 64 * lf + 128 * rt;
    return v[7:0];
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_snap   = '0;
    m_strobe = 1'b0;
    m_q.delete();
    repeat (8) m_q.push_back(1'b0);
  endtask

  task automatic model_step();
    logic [7:0] nxt;
    nxt = exp_byte(udlr_dpad, abxy_btns, st_sel_hm_btns);
    if (m_strobe) begin
      m_q.delete();
      for (int i = 0; i < 8; i++) m_q.push_back(m_snap[i]);
    end else if (cpu_rd_stb && !cpu_wr_stb) begin
      void'(m_q.pop_front());
      m_q.push_back(1'b1);
    end
    if (cpu_wr_stb) m_strobe = cpu_wr_d0;
    m_snap = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (chk_model) begin
      check("model_pad", pad_state, m_snap);
      check("model_d0", {7'd0, joy_d0}, {7'd0, m_strobe ? m_snap[0] : m_q[0]});
    end
  endtask

  task automatic pulse_wr(input logic d);
    cpu_wr_stb = 1'b1;
    cpu_wr_d0  = d;
    tick();
    cpu_wr_stb = 1'b0;
    cpu_wr_d0  = 1'b0;
  endtask

  task automatic set_btn(input logic [3:0] d, input logic [3:0] f, input logic [2:0] s);
    udlr_dpad      = d;
    abxy_btns      = f;
    st_sel_hm_btns = s;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp2[10];
    logic [7:0] b40;
    logic p[24];

    tbl[0] = '{4'b0000, 4'b1100, 3'b110, 8'h0F};
    tbl[1] = '{4'b1110, 4'b0000, 3'b000, 8'h40};
    tbl[2] = '{4'b1111, 4'b0000, 3'b000, 8'h00};
    tbl[3] = '{4'b1011, 4'b0000, 3'b000, 8'h10};
    tbl[4] = '{4'b0001, 4'b0000, 3'b000, 8'h80};
    tbl[5] = '{4'b0000, 4'b0000, 3'b101, 8'h08};
    tbl[6] = '{4'b0101, 4'b0000, 3'b000, 8'hA0};
    tbl[7] = '{4'b0010, 4'b1000, 3'b010, 8'h45};
    exp2 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // 1: reset with everything pressed
    set_btn(4'hF, 4'hF, 3'h7);
    model_reset();
    #23;
    check("rst_d0", {7'd0, joy_d0}, 8'h00);
    check("rst_pad", pad_state, 8'h00);
    @(negedge clk);
    check("rst_pad_late", pad_state, 8'h00);
    reset = 1'b1;
    tick();
    check("rel_pad", pad_state, 8'h0F);

    // vector table: mapping and SOCD
    for (int i = 0; i < 8; i++) begin
      set_btn(tbl[i].d, tbl[i].f, tbl[i].s);
      tick();
      check("tbl_pad", pad_state, tbl[i].exp);
    end

    // 2: A+Start+Right, latch, 10 back-to-back reads
    set_btn(4'b0001, 4'b1000, 3'b100);
    tick();
    pulse_wr(1'b1);
    tick();
    pulse_wr(1'b0);
    for (int i = 0; i < 10; i++) begin
      check("seq2_d0", {7'd0, joy_d0}, {7'd0, exp2[i]});
      cpu_rd_stb = 1'b1;
      tick();
    end
    cpu_rd_stb = 1'b0;

    // 3: strobe held high, B toggled between reads
    set_btn(4'b0000, 4'b0000, 3'b000);
    pulse_wr(1'b1);
    for (int i = 0; i < 6; i++) begin
      abxy_btns = (i % 2 == 1) ? 4'b0100 : 4'b0000;
      cpu_rd_stb = 1'b1;
      tick();
      cpu_rd_stb = 1'b0;
      tick();
      check("seq3_d0", {7'd0, joy_d0}, 8'h00);
      check("seq3_pad", pad_state, (i % 2 == 1) ? 8'h02 : 8'h00);
    end
    pulse_wr(1'b0);

    // 4: Up+Down+Left
    set_btn(4'b1110, 4'b0000, 3'b000);
    tick();
    check("seq4_pad", pad_state, 8'h40);
    pulse_wr(1'b1);
    tick();
    pulse_wr(1'b0);
    b40 = 8'h40;
    for (int i = 0; i < 8; i++) begin
      check("seq4_bit", {7'd0, joy_d0}, {7'd0, b40[i]});
      cpu_rd_stb = 1'b1;
      tick();
      cpu_rd_stb = 1'b0;
    end

    // 5: write and read in the same cycle after latch
    set_btn(4'b0000, 4'b1000, 3'b000);
    tick();
    pulse_wr(1'b1);
    pulse_wr(1'b0);
    cpu_wr_stb = 1'b1;
    cpu_wr_d0  = 1'b0;
    cpu_rd_stb = 1'b1;
    tick();
    cpu_wr_stb = 1'b0;
    cpu_rd_stb = 1'b0;
    check("seq5_noshift", {7'd0, joy_d0}, 8'h01);
    cpu_rd_stb = 1'b1;
    tick();
    cpu_rd_stb = 1'b0;
    check("seq5_next", {7'd0, joy_d0}, 8'h00);

    // reset in the middle of a read sequence
    set_btn(4'b0000, 4'b1000, 3'b101);
    tick();
    pulse_wr(1'b1);
    pulse_wr(1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_d0", {7'd0, joy_d0}, 8'h00);
    check("midrst_pad", pad_state, 8'h00);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("midrst_rel", pad_state, 8'h09);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
`ifdef NES_JOYPAD_TURBO_EN
        set_btn(4'($urandom), 4'($urandom) & 4'b1100, 3'($urandom));
`else
        set_btn(4'($urandom), 4'($urandom), 3'($urandom));
`endif
      end
      cpu_wr_stb = ($urandom_range(0, 7) == 0);
      cpu_wr_d0  = 1'($urandom);
      cpu_rd_stb = 1'($urandom);
      tick();
    end
    cpu_wr_stb = 1'b0;
    cpu_rd_stb = 1'b0;

    // 6: X held alone
`ifdef NES_JOYPAD_TURBO_EN
    chk_model = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    set_btn(4'b0000, 4'b0010, 3'b000);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      p[k] = pad_state[0];
    end
    for (int k = 8; k < 24; k++)
      check("turbo_toggle", {7'd0, p[k]}, {7'd0, ~p[k-4]});
`else
    set_btn(4'b0000, 4'b0010, 3'b000);
    for (int k = 0; k < 24; k++) begin
      tick();
      p[k] = pad_state[0];
      check("noturbo_a", {7'd0, p[k]}, 8'h00);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
